// File: rtl/wptr_full.sv
// wptr_full -- write-side pointer and flag stage of the asynchronous FIFO.
// Keeps binary/Gray write pointers, double-flops the read-domain Gray
// pointer, and produces registered full, almost-full and occupancy.
// Optional build macro: WPTR_ALMOST_FULL_EN (enables the wafull comparator;
// when undefined wafull is tied low and AFULL_THRESH has no effect).
module wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int RAM_DEPTH    = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  WCLK,
  input  logic                  WRSTn,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wcount
);

  localparam int PW = ADDR_WIDTH + 1;

  // Elaboration-time sanity checks on the configuration.
  if (RAM_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("wptr_full: RAM_DEPTH must equal 2**ADDR_WIDTH");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH >= RAM_DEPTH)) begin : g_thresh_chk
    $error("wptr_full: AFULL_THRESH must lie in 1..RAM_DEPTH-1");
  end

  // Binary to reflected Gray code.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary: running XOR from the MSB downwards.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rq1_r;
  logic [PW-1:0] rq2_r;
  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wgray_r;
  logic          wfull_r;
  logic          wafull_r;
  logic [PW-1:0] wcount_r;

  logic          write_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_cmp_s;
  logic [PW-1:0] count_next_s;
  logic          full_next_s;
  logic          afull_next_s;

  // Next-pointer, occupancy and flag evaluation for the coming edge.
  always_comb begin
    // Writes are dropped while full and while the block is held in reset,
    // so the RAM is never written from a stale or cleared pointer.
    write_s      = winc & ~wfull_r & WRSTn;
    wbin_next_s  = wbin_r + {{ADDR_WIDTH{1'b0}}, write_s};
    wgray_next_s = bin2gray(wbin_next_s);
    rbin_s       = gray2bin(rq2_r);
    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the top two bits differ.
    full_cmp_s   = {~rq2_r[PW-1:PW-2], rq2_r[PW-3:0]};
    full_next_s  = (wgray_next_s == full_cmp_s);
    count_next_s = wbin_next_s - rbin_s;
`ifdef WPTR_ALMOST_FULL_EN
    afull_next_s = (count_next_s >= PW'(AFULL_THRESH));
`else
    afull_next_s = 1'b0;
`endif
  end

  // Two-flop synchroniser for the read-domain Gray pointer.
  always_ff @(posedge WCLK or negedge WRSTn) begin
    if (!WRSTn) begin
      rq1_r <= {PW{1'b0}};
      rq2_r <= {PW{1'b0}};
    end else begin
      rq1_r <= rptr_gray;
      rq2_r <= rq1_r;
    end
  end

  // Write pointers, flags and occupancy registers.
  always_ff @(posedge WCLK or negedge WRSTn) begin
    if (!WRSTn) begin
      wbin_r   <= {PW{1'b0}};
      wgray_r  <= {PW{1'b0}};
      wfull_r  <= 1'b0;
      wafull_r <= 1'b0;
      wcount_r <= {PW{1'b0}};
    end else begin
      wbin_r   <= wbin_next_s;
      wgray_r  <= wgray_next_s;
      wfull_r  <= full_next_s;
      wafull_r <= afull_next_s;
      wcount_r <= count_next_s;
    end
  end

  assign write     = write_s;
  assign waddr     = wbin_r[ADDR_WIDTH-1:0];
  assign wptr_gray = wgray_r;
  assign wfull     = wfull_r;
  assign wafull    = wafull_r;
  assign wcount    = wcount_r;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed reset/fill/drain/wrap phases
// plus randomized producer/consumer traffic, all compared against an
// occupancy model built from write and read counts.
module tb_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;
`ifdef WPTR_ALMOST_FULL_EN
  localparam bit AFULL_ON = 1'b1;
`else
  localparam bit AFULL_ON = 1'b0;
`endif

  logic          WCLK = 1'b0;
  logic          WRSTn;
  logic          winc;
  logic [AW:0]   rptr_gray;
  logic          write;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wcount;

  wptr_full #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .WCLK(WCLK), .WRSTn(WRSTn), .winc(winc), .rptr_gray(rptr_gray),
    .write(write), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
    .wafull(wafull), .wcount(wcount)
  );

  always #5 WCLK = ~WCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: total accepted writes, reads issued now and as seen by the
  // write side one and two edges later, plus the registered flag values.
  int m_wr, rd_now, rd_d1, rd_d2, m_cnt;
  bit m_full, m_afull, saw_full;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; rd_now = 0; rd_d1 = 0; rd_d2 = 0; m_cnt = 0;
    m_full = 1'b0; m_afull = 1'b0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    int occ;
    if (winc && !m_full) m_wr++;
    occ     = m_wr - rd_d2;
    m_cnt   = occ;
    m_full  = (occ == DEPTH);
    m_afull = AFULL_ON && (occ >= THR);
    rd_d2   = rd_d1;
    rd_d1   = rd_now;
  endtask

  task automatic check_outputs();
    chk("write",     32'(write),     32'(winc && !m_full));
    chk("waddr",     32'(waddr),     32'(m_wr % DEPTH));
    chk("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wr)));
    chk("wfull",     32'(wfull),     32'(m_full));
    chk("wafull",    32'(wafull),    32'(m_afull));
    chk("wcount",    32'(wcount),    32'(m_cnt));
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle, step model.
  task automatic cycle(input bit w, input bit adv);
    winc = w;
    if (adv) rd_now++;
    rptr_gray = to_gray(rd_now);
    #4;
    check_outputs();
    if (wfull) saw_full = 1'b1;
    model_step();
    @(posedge WCLK);
    #1;
  endtask

  task automatic do_reset();
    WRSTn = 1'b0; winc = 1'b1; rptr_gray = '0;
    model_reset();
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_gray",  32'(wptr_gray), 32'd0);
    chk("rst_full",  32'(wfull), 32'd0);
    chk("rst_count", 32'(wcount), 32'd0);
    chk("rst_afull", 32'(wafull), 32'd0);
    @(posedge WCLK);
    #1;
    chk("rst_hold_write", 32'(write), 32'd0);
    WRSTn = 1'b1;
  endtask

  initial begin
    WRSTn = 1'b0; winc = 1'b0; rptr_gray = '0;
    model_reset();
    @(posedge WCLK);
    do_reset();

    // Fill from empty with no reads.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0);
      if (i == THR - 1) chk("afull_11", 32'(wafull), 32'd0);
      if (i == THR)     chk("afull_12", 32'(wafull), 32'(AFULL_ON));
    end
    winc = 1'b1;
    #1;
    chk("full_after_16",  32'(wfull), 32'd1);
    chk("fill_gray",      32'(wptr_gray), 32'h18);
    chk("ovf_write",      32'(write), 32'd0);
    chk("ovf_waddr",      32'(waddr), 32'd0);
    chk("fill_count",     32'(wcount), 32'd16);
    #(-1 + 1);
    cycle(1'b1, 1'b0);

    // Drain release: one read becomes visible on the third edge.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("drain_full_e2", 32'(wfull), 32'd1);
    cycle(1'b0, 1'b0);
    chk("drain_full_e3",  32'(wfull), 32'd0);
    chk("drain_count_e3", 32'(wcount), 32'd15);
    cycle(1'b1, 1'b0);
    chk("refill_full", 32'(wfull), 32'd1);
    cycle(1'b1, 1'b0);
    chk("refill_hold", 32'(wcount), 32'd16);

    // Asynchronous reset in the middle of a fill.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    chk("mid_count7", 32'(wcount), 32'd7);
    winc = 1'b1;
    #2;
    WRSTn = 1'b0;
    rptr_gray = '0;
    model_reset();
    #1;
    chk("mid_write", 32'(write), 32'd0);
    chk("mid_waddr", 32'(waddr), 32'd0);
    chk("mid_gray",  32'(wptr_gray), 32'd0);
    chk("mid_full",  32'(wfull), 32'd0);
    chk("mid_count", 32'(wcount), 32'd0);
    @(posedge WCLK);
    #1;
    WRSTn = 1'b1;

    // Wrap: 40 writes with the reader trailing closely; never full.
    saw_full = 1'b0;
    for (int c = 0; c < 200 && m_wr < 40; c++) begin
      cycle(1'b1, (rd_now + 2) < m_wr);
    end
    chk("wrap_writes", 32'(m_wr), 32'd40);
    chk("wrap_nofull", 32'(saw_full), 32'd0);

    // Random traffic: slow reader (fills up), then fast reader.
    for (int c = 0; c < 300; c++) begin
      cycle($urandom_range(0, 3) != 0, (rd_now < m_wr) && ($urandom_range(0, 2) == 0));
    end
    for (int c = 0; c < 300; c++) begin
      cycle($urandom_range(0, 1) != 0, (rd_now < m_wr) && ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
